// File: rtl/jogo_pkg.sv
// Shared definitions for the game UART sequencer: FSM state codes, header
// default, snapshot layout and packet byte builder.
// SEQ_UART_CHECKSUM_EN adds a fifth XOR checksum byte to every packet.
package jogo_pkg;

    typedef enum logic [3:0] {
        OCIOSO         = 4'd0,
        CAPTURA        = 4'd1,
        EMITE          = 4'd2,
        AGUARDA_ACEITE = 4'd3,
        AGUARDA_FIM    = 4'd4,
        FIM            = 4'd5
    } estado_seq_t;

    localparam logic [7:0] CABECALHO_PADRAO = 8'hA5;

    // Field order fixes the snapshot bit offsets (estado at [17:14]).
    typedef struct packed {
        logic [3:0] est;
        logic [3:0] mac;
        logic [3:0] mic;
        logic [1:0] jog;
        logic [1:0] res_macro;
        logic [1:0] res_jogo;
    } snapshot_t;

`ifdef SEQ_UART_CHECKSUM_EN
    localparam int N_BYTES = 5;
`else
    localparam int N_BYTES = 4;
`endif

    function automatic logic [7:0] byte_pacote(
        input logic [7:0] cab,
        input snapshot_t  s,
        input logic [2:0] i
    );
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] b3;
        logic [7:0] r;
        b1 = {s.est, s.mac};
        b2 = {s.mic, s.jog, s.res_macro};
        b3 = {s.res_jogo, 6'b0};
        r  = 8'h00;
        case (i)
            3'd0:    r = cab;
            3'd1:    r = b1;
            3'd2:    r = b2;
            3'd3:    r = b3;
`ifdef SEQ_UART_CHECKSUM_EN
            3'd4:    r = cab ^ b1 ^ b2 ^ b3;
`endif
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/temporizador_keepalive.sv
// Keep-alive timer: counts enabled cycles and pulses expirou on count
// PERIODO-1, then restarts. PERIODO=0 disables the pulse entirely.
// Ports: clock, reset (async active-low), limpa (sync clear), conta
// (count enable), expirou (expiry pulse, combinational).
module temporizador_keepalive #(
    parameter int unsigned PERIODO = 0,
    parameter int unsigned LARGURA = 24
) (
    input  logic clock,
    input  logic reset,
    input  logic limpa,
    input  logic conta,
    output logic expirou
);

    localparam int unsigned ALVO_I = (PERIODO > 0) ? PERIODO - 1 : 0;
    localparam logic [LARGURA-1:0] ALVO = LARGURA'(ALVO_I);
    localparam logic ATIVO = (PERIODO > 0);

    logic [LARGURA-1:0] contagem;
    logic               no_alvo;

    assign no_alvo = (contagem == ALVO);
    assign expirou = ATIVO && conta && !limpa && no_alvo;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contagem <= '0;
        end else if (limpa) begin
            contagem <= '0;
        end else if (conta) begin
            contagem <= no_alvo ? '0 : contagem + 1'b1;
        end
    end

endmodule

// File: rtl/sequenciador_uart_jogo.sv
// Streams a frozen game-state snapshot to a byte UART tx whenever the state
// changes (or on keep-alive expiry). Ports: clock, reset (async active-low),
// habilita, game-state inputs, tx_pronto / tx_partida / tx_dado handshake,
// ocupado, db_estado. SEQ_UART_CHECKSUM_EN appends an XOR checksum byte.
module sequenciador_uart_jogo
    import jogo_pkg::*;
#(
    parameter logic [7:0]  CABECALHO  = CABECALHO_PADRAO,
    parameter int unsigned PERIODO_KA = 0,
    parameter int unsigned LARGURA_KA = 24
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic [3:0] macro,
    input  logic [3:0] micro,
    input  logic [3:0] estado,
    input  logic [1:0] resultado_macro,
    input  logic [1:0] resultado_jogo,
    input  logic [1:0] jogador,
    input  logic       tx_pronto,
    output logic       tx_partida,
    output logic [7:0] tx_dado,
    output logic       ocupado,
    output logic [3:0] db_estado
);

    localparam logic [2:0] ULTIMO = 3'(N_BYTES - 1);

    estado_seq_t atual;
    estado_seq_t proximo;
    snapshot_t   s_atual;
    snapshot_t   snapshot;
    snapshot_t   ultimo_enviado;
    logic        pendente;
    logic [2:0]  indice;
    logic [7:0]  dado_q;
    logic [7:0]  byte_atual;
    logic        ocupado_q;
    logic        ka_expirou;
    logic        ka_limpa;
    logic        em_pacote;

    assign s_atual = '{
        est:       estado,
        mac:       macro,
        mic:       micro,
        jog:       jogador,
        res_macro: resultado_macro,
        res_jogo:  resultado_jogo
    };

    assign byte_atual = byte_pacote(CABECALHO, snapshot, indice);
    assign ka_limpa   = (atual == FIM) || !habilita;
    assign em_pacote  = (atual == EMITE) || (atual == AGUARDA_ACEITE) ||
                        (atual == AGUARDA_FIM) || (atual == FIM);

    temporizador_keepalive #(
        .PERIODO (PERIODO_KA),
        .LARGURA (LARGURA_KA)
    ) u_keepalive (
        .clock   (clock),
        .reset   (reset),
        .limpa   (ka_limpa),
        .conta   (atual == OCIOSO),
        .expirou (ka_expirou)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) atual <= OCIOSO;
        else        atual <= proximo;
    end

    always_comb begin
        proximo    = atual;
        tx_partida = 1'b0;
        unique case (atual)
            OCIOSO: begin
                if (habilita && (s_atual != ultimo_enviado || ka_expirou))
                    proximo = CAPTURA;
            end
            CAPTURA: proximo = EMITE;
            EMITE: begin
                if (tx_pronto) begin
                    tx_partida = 1'b1;
                    proximo    = AGUARDA_ACEITE;
                end
            end
            AGUARDA_ACEITE: begin
                if (!tx_pronto) proximo = AGUARDA_FIM;
            end
            AGUARDA_FIM: begin
                if (tx_pronto) proximo = (indice == ULTIMO) ? FIM : EMITE;
            end
            FIM: proximo = (pendente && habilita) ? CAPTURA : OCIOSO;
            default: proximo = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            snapshot       <= '0;
            ultimo_enviado <= '0;
            indice         <= '0;
            dado_q         <= '0;
            ocupado_q      <= 1'b0;
        end else begin
            if (atual == CAPTURA) begin
                snapshot  <= s_atual;
                indice    <= '0;
                ocupado_q <= 1'b1;
            end
            if (atual == EMITE && tx_pronto)
                dado_q <= byte_atual;
            if (atual == AGUARDA_FIM && tx_pronto && indice != ULTIMO)
                indice <= indice + 1'b1;
            if (atual == FIM) begin
                ultimo_enviado <= snapshot;
                ocupado_q      <= 1'b0;
            end
        end
    end

    // Sticky: any divergence from the frozen snapshot while a packet is
    // in flight requests exactly one follow-up packet.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pendente <= 1'b0;
        end else if (atual == CAPTURA || atual == OCIOSO) begin
            pendente <= 1'b0;
        end else if (em_pacote && s_atual != snapshot) begin
            pendente <= 1'b1;
        end
    end

    // The byte is visible in the same cycle as the start pulse, then held.
    assign tx_dado   = (atual == EMITE && tx_pronto) ? byte_atual : dado_q;
    assign ocupado   = ocupado_q;
    assign db_estado = atual;

endmodule

// File: tb/tb_sequenciador_uart_jogo.sv
// Bench for sequenciador_uart_jogo: table vectors, hand-written corner
// sequences and randomized state changes checked against a packet model.
`timescale 1ns/1ps
module tb_sequenciador_uart_jogo;

`ifdef SEQ_UART_CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif
    localparam int PER_KA  = 100;
    localparam int OCUP_TX = 10;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        habilita = 1'b0;
    logic        habilita_ka = 1'b0;
    logic [17:0] s_cur = '0;
    logic [3:0]  estado, macro, micro;
    logic [1:0]  jogador, rm, rj;
    assign {estado, macro, micro, jogador, rm, rj} = s_cur;

    logic       tx_pronto, tx_partida, ocupado;
    logic [7:0] tx_dado;
    logic [3:0] db_estado;
    logic       tx_pronto_ka, tx_partida_ka, ocupado_ka;
    logic [7:0] tx_dado_ka;
    logic [3:0] db_estado_ka;

    int vectors = 0;
    int miscompares = 0;
    int ciclo = 0;
    int busy = 0;
    int busy_ka = 0;
    int erros_mon = 0;
    int erros_ka = 0;
    logic segura = 1'b0;
    logic prev_p = 1'b0;
    logic prev_pk = 1'b0;
    logic [7:0] q_bytes[$];
    logic [7:0] q_ka[$];
    int         q_ka_ciclo[$];

    always #5 clock = ~clock;
    always @(posedge clock) ciclo <= ciclo + 1;

    assign tx_pronto    = (busy == 0) && !segura;
    assign tx_pronto_ka = (busy_ka == 0);

    sequenciador_uart_jogo dut (
        .clock(clock), .reset(reset), .habilita(habilita),
        .macro(macro), .micro(micro), .estado(estado),
        .resultado_macro(rm), .resultado_jogo(rj), .jogador(jogador),
        .tx_pronto(tx_pronto), .tx_partida(tx_partida), .tx_dado(tx_dado),
        .ocupado(ocupado), .db_estado(db_estado)
    );

    sequenciador_uart_jogo #(.PERIODO_KA(PER_KA)) dut_ka (
        .clock(clock), .reset(reset), .habilita(habilita_ka),
        .macro(macro), .micro(micro), .estado(estado),
        .resultado_macro(rm), .resultado_jogo(rj), .jogador(jogador),
        .tx_pronto(tx_pronto_ka), .tx_partida(tx_partida_ka),
        .tx_dado(tx_dado_ka), .ocupado(ocupado_ka), .db_estado(db_estado_ka)
    );

    // UART tx models: accept a byte on a start pulse, then busy 10 cycles.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy   <= 0;
            prev_p <= 1'b0;
        end else begin
            if (tx_partida) begin
                if (!tx_pronto || prev_p || !ocupado) begin
                    erros_mon <= erros_mon + 1;
                    $display("FAIL pulso: pronto=%0b repetido=%0b ocupado=%0b, required 1/0/1",
                             tx_pronto, prev_p, ocupado);
                end
                q_bytes.push_back(tx_dado);
                busy <= OCUP_TX;
            end else if (busy > 0) begin
                busy <= busy - 1;
            end
            prev_p <= tx_partida;
        end
    end

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_ka <= 0;
            prev_pk <= 1'b0;
        end else begin
            if (tx_partida_ka) begin
                if (!tx_pronto_ka || prev_pk) begin
                    erros_ka <= erros_ka + 1;
                    $display("FAIL pulso_ka: pronto=%0b repetido=%0b, required 1/0",
                             tx_pronto_ka, prev_pk);
                end
                q_ka.push_back(tx_dado_ka);
                q_ka_ciclo.push_back(ciclo);
                busy_ka <= OCUP_TX;
            end else if (busy_ka > 0) begin
                busy_ka <= busy_ka - 1;
            end
            prev_pk <= tx_partida_ka;
        end
    end

    task automatic chk(input string nome, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nome, got, exp);
        end
    endtask

    // Packet model: header, {estado,macro}, {micro,jog,rm}, {rj,0}, xor.
    function automatic logic [7:0] exp_byte(input logic [17:0] s, input int i);
        logic [7:0] b[5];
        b[0] = 8'hA5;
        b[1] = s[17:10];
        b[2] = s[9:2];
        b[3] = {s[1:0], 6'b0};
        b[4] = b[0] ^ b[1] ^ b[2] ^ b[3];
        return b[i];
    endfunction

    function automatic logic [17:0] mk(input logic [3:0] e, m, c,
                                      input logic [1:0] j, r1, r2);
        return {e, m, c, j, r1, r2};
    endfunction

    task automatic espera(input int alvo, input int limite, input string nome);
        int n = 0;
        @(negedge clock);
        while (!(q_bytes.size() >= alvo && db_estado == 4'd0) && n < limite) begin
            @(negedge clock);
            n++;
        end
        chk(nome, 32'(n < limite), 1);
    endtask

    task automatic chk_pacote(input string nome, input int base,
                              input logic [17:0] s);
        for (int k = 0; k < NB; k++)
            chk(nome, q_bytes[base + k], exp_byte(s, k));
    endtask

    typedef struct {
        logic [17:0] s;
        logic [7:0]  b1, b2, b3, ck;
    } vet_t;

    vet_t tab[4];

    initial begin
        int base;
        int n;
        int quiet;
        int ult;
        int nbytes;
        logic [31:0] s_val;
        logic [17:0] aplicado[$];
        logic [17:0] sp;
        logic [7:0]  b3;
        logic        achou;

        tab[0] = '{mk(4'h3, 4'h5, 4'h6, 2'd0, 2'd2, 2'd1), 8'h35, 8'h62, 8'h40, 8'hB2};
        tab[1] = '{mk(4'hF, 4'h0, 4'h1, 2'd3, 2'd3, 2'd2), 8'hF0, 8'h1F, 8'h80, 8'hCA};
        tab[2] = '{mk(4'h0, 4'hA, 4'hC, 2'd1, 2'd0, 2'd3), 8'h0A, 8'hC4, 8'hC0, 8'hAB};
        tab[3] = '{mk(4'h9, 4'h9, 4'h9, 2'd2, 2'd1, 2'd0), 8'h99, 8'h99, 8'h00, 8'hA5};

        #1;
        chk("rst_partida", tx_partida, 0);
        chk("rst_dado", tx_dado, 0);
        chk("rst_ocupado", ocupado, 0);
        chk("rst_db", db_estado, 0);
        repeat (3) @(negedge clock);
        reset    = 1'b1;
        habilita = 1'b1;
        repeat (3) @(negedge clock);
        chk("idle_sem_bytes", q_bytes.size(), 0);

        // Table vectors: packet content and first-byte latency.
        for (int i = 0; i < 4; i++) begin
            s_cur = tab[i].s;
            base  = q_bytes.size();
            if (i == 0) begin
                @(negedge clock);
                chk("lat_captura_partida", tx_partida, 0);
                chk("lat_captura_db", db_estado, 1);
                @(negedge clock);
                chk("lat_partida", tx_partida, 1);
                chk("lat_dado", tx_dado, 8'hA5);
                chk("ocupado_emite", ocupado, 1);
            end
            espera(base + NB, 400, "tab_fim");
            chk("tab_b0", q_bytes[base], 8'hA5);
            chk("tab_b1", q_bytes[base + 1], tab[i].b1);
            chk("tab_b2", q_bytes[base + 2], tab[i].b2);
            chk("tab_b3", q_bytes[base + 3], tab[i].b3);
`ifdef SEQ_UART_CHECKSUM_EN
            chk("tab_b4", q_bytes[base + 4], tab[i].ck);
`endif
            chk("tab_tamanho", q_bytes.size() - base, NB);
            chk("tab_ocupado_fim", ocupado, 0);
            @(negedge clock);
        end

        // Two micro changes mid-packet collapse into one follow-up.
        base  = q_bytes.size();
        s_cur = mk(4'h1, 4'h2, 4'h3, 2'd1, 2'd1, 2'd1);
        sp    = s_cur;
        n = 0;
        while (!ocupado && n < 20) begin @(negedge clock); n++; end
        chk("pend_ocupado", ocupado, 1);
        repeat (5) @(negedge clock);
        s_cur[9:6] = 4'h4;
        repeat (5) @(negedge clock);
        s_cur[9:6] = 4'h7;
        espera(base + 2 * NB, 600, "pend_fim");
        repeat (300) @(negedge clock);
        chk("pend_qtd", q_bytes.size() - base, 2 * NB);
        chk_pacote("pend_p1", base, sp);
        chk_pacote("pend_p2", base + NB, s_cur);

        // tx_pronto held low in EMITE.
        segura = 1'b1;
        s_cur  = mk(4'h2, 4'h4, 4'h6, 2'd2, 2'd0, 2'd1);
        base   = q_bytes.size();
        n = 0;
        repeat (50) begin
            @(negedge clock);
            if (tx_partida) n++;
        end
        chk("segura_sem_pulso", n, 0);
        chk("segura_db", db_estado, 2);
        segura = 1'b0;
        @(posedge clock);
        #1;
        chk("segura_pulso", q_bytes.size() - base, 1);
        espera(base + NB, 400, "segura_fim");
        chk_pacote("segura_pac", base, s_cur);

        // Async reset in AGUARDA_FIM, then a fresh packet from B0.
        s_cur = mk(4'h6, 4'h1, 4'h8, 2'd1, 2'd2, 2'd3);
        n = 0;
        while (db_estado != 4'd4 && n < 50) begin @(negedge clock); n++; end
        chk("rst_meio_alcance", db_estado, 4);
        #2 reset = 1'b0;
        #1;
        chk("rst_meio_partida", tx_partida, 0);
        chk("rst_meio_dado", tx_dado, 0);
        chk("rst_meio_ocupado", ocupado, 0);
        chk("rst_meio_db", db_estado, 0);
        @(negedge clock);
        reset = 1'b1;
        q_bytes.delete();
        espera(NB, 400, "rst_novo_fim");
        chk("rst_novo_tam", q_bytes.size(), NB);
        chk_pacote("rst_novo", 0, s_cur);

        // habilita=0: no new packets; re-enable sends the latest state.
        habilita = 1'b0;
        s_cur = mk(4'h7, 4'h7, 4'h7, 2'd3, 2'd3, 2'd3);
        base  = q_bytes.size();
        repeat (200) @(negedge clock);
        chk("hab0_sem_pacote", q_bytes.size() - base, 0);
        habilita = 1'b1;
        espera(base + NB, 400, "hab1_fim");
        chk_pacote("hab1_pac", base, s_cur);

        // Randomized monotonic changes: packets follow the applied order.
        base  = q_bytes.size();
        s_val = 32'h100;
        for (int it = 0; it < 30; it++) begin
            s_val = s_val + $urandom_range(1, 4000);
            s_cur = s_val[17:0];
            aplicado.push_back(s_cur);
            repeat ($urandom_range(1, 40)) @(negedge clock);
        end
        n = 0;
        quiet = 0;
        while (quiet < 60 && n < 4000) begin
            @(negedge clock);
            n++;
            if (db_estado == 4'd0) quiet++;
            else quiet = 0;
        end
        chk("rand_quieto", 32'(quiet >= 60), 1);
        nbytes = q_bytes.size() - base;
        chk("rand_multiplo", nbytes % NB, 0);
        ult = -1;
        for (int p = 0; p < nbytes / NB; p++) begin
            b3 = q_bytes[base + p * NB + 3];
            sp = {q_bytes[base + p * NB + 1], q_bytes[base + p * NB + 2], b3[7:6]};
            chk("rand_cab", q_bytes[base + p * NB], 8'hA5);
            chk("rand_b3_zero", b3[5:0], 0);
`ifdef SEQ_UART_CHECKSUM_EN
            chk("rand_ck", q_bytes[base + p * NB + 4], exp_byte(sp, 4));
`endif
            achou = 1'b0;
            for (int j = ult + 1; j < aplicado.size(); j++) begin
                if (!achou && aplicado[j] == sp) begin
                    achou = 1'b1;
                    ult = j;
                end
            end
            chk("rand_ordem", achou, 1);
        end
        chk("rand_final", ult, aplicado.size() - 1);

        // Keep-alive instance: identical packets at a fixed period.
        q_ka.delete();
        q_ka_ciclo.delete();
        habilita_ka = 1'b1;
        n = 0;
        while (q_ka.size() < 4 * NB && n < 1500) begin @(negedge clock); n++; end
        chk("ka_alcance", 32'(n < 1500), 1);
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < NB; k++)
                chk("ka_byte", q_ka[p * NB + k], exp_byte(s_cur, k));
        for (int p = 1; p < 4; p++)
            chk("ka_intervalo", q_ka_ciclo[p * NB] - q_ka_ciclo[(p - 1) * NB],
                PER_KA + 12 * NB + 2);
        habilita_ka = 1'b0;
        repeat (200) @(negedge clock);
        n = q_ka.size();
        repeat (400) @(negedge clock);
        chk("ka_desabilitado", q_ka.size(), n);

        chk("monitor_erros", erros_mon, 0);
        chk("monitor_ka_erros", erros_ka, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
